// File: rtl/cv32e40s_rvfi_pkg.sv
// cv32e40s_rvfi_pkg: trace record layout, buffer state encoding and marker builder
package cv32e40s_rvfi_pkg;
  typedef struct packed {
    logic        marker;
    logic [31:0] pc;
    logic [4:0]  rs1_addr;
    logic [31:0] rs1_rdata;
    logic [4:0]  rs2_addr;
    logic [31:0] rs2_rdata;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [31:0] mem_rdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
  } rvfi_trace_rec_t;
  typedef enum logic {NORMAL, DROPPING} trace_buf_state_e;
  function automatic rvfi_trace_rec_t marker_rec(input logic [31:0] cnt);
    marker_rec = '0;
    marker_rec.marker = 1'b1;
    marker_rec.pc = cnt;
  endfunction
endpackage

// File: rtl/rvfi_trace_fifo.sv
// rvfi_trace_fifo: DEPTH-entry registered circular FIFO of trace records with sync flush
module rvfi_trace_fifo
  import cv32e40s_rvfi_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            push_i,
  input  rvfi_trace_rec_t data_i,
  input  logic            pop_i,
  output rvfi_trace_rec_t data_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [AW:0]     level_o
);
  rvfi_trace_rec_t mem [DEPTH];
  logic [AW-1:0] rptr, wptr;
  logic wr, rd;
  assign full_o = level_o == (AW+1)'(DEPTH);
  assign empty_o = level_o == '0;
  assign rd = pop_i & ~empty_o;
  assign wr = push_i & (~full_o | rd);
  assign data_o = empty_o ? '0 : mem[rptr];
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      rptr <= '0;
      wptr <= '0;
      level_o <= '0;
    end else if (flush_i) begin
      rptr <= '0;
      wptr <= '0;
      level_o <= '0;
    end else begin
      rptr <= rd ? rptr + AW'(1) : rptr;
      wptr <= wr ? wptr + AW'(1) : wptr;
      level_o <= level_o + (AW+1)'(wr) - (AW+1)'(rd);
    end
  always_ff @(posedge clk_i)
    if (wr && !flush_i) mem[wptr] <= data_i;
endmodule

// File: rtl/rvfi_trace_buffer.sv
// rvfi_trace_buffer: RVFI retirement capture FIFO with drop counting and lost-record markers
module rvfi_trace_buffer
  import cv32e40s_rvfi_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DROP_CNT_W = 16,
  parameter int NMEM = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     enable_i,
  input  logic                     clear_i,
  input  logic                     rvfi_valid,
  input  logic [31:0]              rvfi_pc_rdata,
  input  logic [4:0]               rvfi_rs1_addr,
  input  logic [4:0]               rvfi_rs2_addr,
  input  logic [4:0]               rvfi_rd_addr,
  input  logic [31:0]              rvfi_rs1_rdata,
  input  logic [31:0]              rvfi_rs2_rdata,
  input  logic [31:0]              rvfi_rd_wdata,
  input  logic [32*NMEM-1:0]       rvfi_mem_addr,
  input  logic [32*NMEM-1:0]       rvfi_mem_rdata,
  input  logic [32*NMEM-1:0]       rvfi_mem_wdata,
  input  logic [4*NMEM-1:0]        rvfi_mem_rmask,
  input  logic [4*NMEM-1:0]        rvfi_mem_wmask,
  output logic                     trace_valid_o,
  input  logic                     trace_ready_i,
  output rvfi_trace_rec_t          trace_rec_o,
  output logic [$clog2(DEPTH):0]   fill_level_o,
  output logic                     overflow_o,
  output logic [DROP_CNT_W-1:0]    drop_cnt_o
);
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("rvfi_trace_buffer: DEPTH must be a power of two and at least 2");
  end
  trace_buf_state_e state_q, state_d;
  logic [DROP_CNT_W-1:0] cnt_d;
  logic ovf_d, push, pop, space, marker_wr, wr, full, empty;
  rvfi_trace_rec_t ret_rec, wr_rec;
  logic unused_mem;
  assign unused_mem = ^{rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata, rvfi_mem_rmask, rvfi_mem_wmask};
  assign push = rvfi_valid & enable_i & ~clear_i;
  assign pop = trace_valid_o & trace_ready_i & ~clear_i;
  assign space = ~full | pop;
  assign marker_wr = (state_q == DROPPING) & space & ~clear_i;
  assign wr = marker_wr | ((state_q == NORMAL) & push & space);
  assign trace_valid_o = ~empty;
  assign ret_rec = '{
    marker:    1'b0,
    pc:        rvfi_pc_rdata,
    rs1_addr:  rvfi_rs1_addr,
    rs1_rdata: rvfi_rs1_rdata,
    rs2_addr:  rvfi_rs2_addr,
    rs2_rdata: rvfi_rs2_rdata,
    rd_addr:   rvfi_rd_addr,
    rd_wdata:  rvfi_rd_wdata,
    mem_addr:  rvfi_mem_addr[31:0],
    mem_rmask: rvfi_mem_rmask[3:0],
    mem_rdata: rvfi_mem_rdata[31:0],
    mem_wmask: rvfi_mem_wmask[3:0],
    mem_wdata: rvfi_mem_wdata[31:0]
  };
  assign wr_rec = marker_wr ? marker_rec(32'(drop_cnt_o)) : ret_rec;
  always_comb begin
    state_d = state_q;
    cnt_d = drop_cnt_o;
    ovf_d = overflow_o;
    if (state_q == NORMAL) begin
      if (push && !space) begin
        state_d = DROPPING;
        cnt_d = DROP_CNT_W'(1);
        ovf_d = 1'b1;
      end
    end else if (space) begin
      state_d = push ? DROPPING : NORMAL;
      cnt_d = push ? DROP_CNT_W'(1) : '0;
    end else if (push && !(&drop_cnt_o)) begin
      cnt_d = drop_cnt_o + DROP_CNT_W'(1);
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= NORMAL;
      drop_cnt_o <= '0;
      overflow_o <= 1'b0;
    end else if (clear_i) begin
      state_q <= NORMAL;
      drop_cnt_o <= '0;
      overflow_o <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_cnt_o <= cnt_d;
      overflow_o <= ovf_d;
    end
  rvfi_trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (clear_i),
    .push_i  (wr),
    .data_i  (wr_rec),
    .pop_i   (pop),
    .data_o  (trace_rec_o),
    .full_o  (full),
    .empty_o (empty),
    .level_o (fill_level_o)
  );
endmodule

// File: tb/tb_rvfi_trace_buffer.sv
// tb_rvfi_trace_buffer: directed self-checking bench for rvfi_trace_buffer
module tb_rvfi_trace_buffer;
  import cv32e40s_rvfi_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b1;
  logic clr = 1'b0;
  logic rv = 1'b0;
  logic ready = 1'b0;
  logic [31:0] pc = '0, rs1d = '0, rs2d = '0, rdd = '0;
  logic [4:0] rs1a = '0, rs2a = '0, rda = '0;
  logic [63:0] maddr = '0, mrd = '0, mwd = '0;
  logic [7:0] rmask = '0, wmask = '0;
  logic valid, valid4, ovf, ovf4;
  rvfi_trace_rec_t rec, rec4;
  logic [3:0] fill, fill4;
  logic [15:0] dc;
  logic [3:0] dc4;
  int vecs = 0;
  int errs = 0;
  always #5 clk = ~clk;
  rvfi_trace_buffer #(.DEPTH(8), .DROP_CNT_W(16), .NMEM(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .clear_i(clr), .rvfi_valid(rv),
    .rvfi_pc_rdata(pc), .rvfi_rs1_addr(rs1a), .rvfi_rs2_addr(rs2a), .rvfi_rd_addr(rda),
    .rvfi_rs1_rdata(rs1d), .rvfi_rs2_rdata(rs2d), .rvfi_rd_wdata(rdd),
    .rvfi_mem_addr(maddr), .rvfi_mem_rdata(mrd), .rvfi_mem_wdata(mwd),
    .rvfi_mem_rmask(rmask), .rvfi_mem_wmask(wmask),
    .trace_valid_o(valid), .trace_ready_i(ready), .trace_rec_o(rec),
    .fill_level_o(fill), .overflow_o(ovf), .drop_cnt_o(dc)
  );
  rvfi_trace_buffer #(.DEPTH(8), .DROP_CNT_W(4), .NMEM(2)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .clear_i(clr), .rvfi_valid(rv),
    .rvfi_pc_rdata(pc), .rvfi_rs1_addr(rs1a), .rvfi_rs2_addr(rs2a), .rvfi_rd_addr(rda),
    .rvfi_rs1_rdata(rs1d), .rvfi_rs2_rdata(rs2d), .rvfi_rd_wdata(rdd),
    .rvfi_mem_addr(maddr), .rvfi_mem_rdata(mrd), .rvfi_mem_wdata(mwd),
    .rvfi_mem_rmask(rmask), .rvfi_mem_wmask(wmask),
    .trace_valid_o(valid4), .trace_ready_i(ready), .trace_rec_o(rec4),
    .fill_level_o(fill4), .overflow_o(ovf4), .drop_cnt_o(dc4)
  );
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [31:0] p);
    rv = v;
    pc = p;
    rs1a = p[6:2];
    rs1d = p ^ 32'h1111_0000;
    rs2a = p[7:3];
    rs2d = ~p;
    rda = 5'd7;
    rdd = p + 32'd1;
    maddr = {32'hDEAD_BEEF, p + 32'h1000};
    mrd = {32'hFFFF_FFFF, p ^ 32'h5555};
    mwd = {32'hCAFE_0000, p << 1};
    rmask = 8'hF3;
    wmask = 8'hE5;
  endtask
  function automatic rvfi_trace_rec_t exp_rec(input logic [31:0] p);
    exp_rec = '{marker: 1'b0, pc: p, rs1_addr: p[6:2], rs1_rdata: p ^ 32'h1111_0000,
                rs2_addr: p[7:3], rs2_rdata: ~p, rd_addr: 5'd7, rd_wdata: p + 32'd1,
                mem_addr: p + 32'h1000, mem_rmask: 4'h3, mem_rdata: p ^ 32'h5555,
                mem_wmask: 4'h5, mem_wdata: p << 1};
  endfunction
  task automatic do_clear();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask
  initial begin
    drive(1'b0, 32'h0);
    #2;
    chk("rst_valid", valid, 0);
    chk("rst_rec", rec, 0);
    chk("rst_fill", fill, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_dc", dc, 0);
    #10;
    rst_n = 1'b1;
    step();
    ready = 1'b1;
    drive(1'b1, 32'h80);
    chk("t1_pre_valid", valid, 0);
    step();
    drive(1'b0, 32'h0);
    chk("t1_valid", valid, 1);
    chk("t1_rec", rec, exp_rec(32'h80));
    chk("t1_fill", fill, 1);
    step();
    chk("t1_valid_after", valid, 0);
    chk("t1_fill_after", fill, 0);
    ready = 1'b0;
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, 32'h100 + 32'(4 * i));
      step();
    end
    drive(1'b0, 32'h0);
    chk("t2_fill", fill, 8);
    chk("t2_ovf", ovf, 1);
    chk("t2_dc", dc, 3);
    step();
    chk("t2_hold_pc", rec.pc, 32'h100);
    ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t2_drain_valid", valid, 1);
      chk("t2_drain_rec", rec, exp_rec(32'h100 + 32'(4 * i)));
      step();
    end
    chk("t2_mk_marker", rec.marker, 1);
    chk("t2_mk_rec", rec, marker_rec(32'h3));
    step();
    chk("t2_end_valid", valid, 0);
    chk("t2_end_fill", fill, 0);
    chk("t2_end_dc", dc, 0);
    chk("t2_end_ovf", ovf, 1);
    ready = 1'b0;
    do_clear();
    chk("t3_clr_ovf", ovf, 0);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h200 + 32'(4 * i));
      step();
    end
    chk("t3_fill_full", fill, 8);
    ready = 1'b1;
    for (int j = 0; j < 20; j++) begin
      drive(1'b1, 32'h200 + 32'(4 * (8 + j)));
      chk("t3_head", rec.pc, 32'h200 + 32'(4 * j));
      step();
      chk("t3_fill", fill, 8);
      chk("t3_dc", dc, 0);
    end
    chk("t3_ovf", ovf, 0);
    drive(1'b0, 32'h0);
    for (int k = 0; k < 8; k++) begin
      chk("t3_drain", rec.pc, 32'h200 + 32'(4 * (20 + k)));
      step();
    end
    chk("t3_empty", valid, 0);
    ready = 1'b0;
    do_clear();
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, 32'h300 + 32'(4 * i));
      step();
    end
    chk("t4_dc3", dc, 3);
    ready = 1'b1;
    drive(1'b1, 32'h3ff);
    step();
    chk("t4_dc1", dc, 1);
    chk("t4_fill", fill, 8);
    ready = 1'b0;
    drive(1'b1, 32'h3fe);
    step();
    chk("t4_dc2", dc, 2);
    drive(1'b0, 32'h0);
    ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      chk("t4_drain", rec, exp_rec(32'h300 + 32'(4 * i)));
      step();
    end
    chk("t4_mk3", rec, marker_rec(32'h3));
    step();
    chk("t4_mk2", rec, marker_rec(32'h2));
    step();
    chk("t4_empty", valid, 0);
    chk("t4_dc0", dc, 0);
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h400 + 32'(4 * i));
      step();
    end
    chk("t5_fill5", fill, 5);
    chk("t5_ovf1", ovf, 1);
    clr = 1'b1;
    ready = 1'b1;
    drive(1'b1, 32'h4ff);
    step();
    clr = 1'b0;
    chk("t5_fill", fill, 0);
    chk("t5_valid", valid, 0);
    chk("t5_ovf", ovf, 0);
    chk("t5_dc", dc, 0);
    ready = 1'b0;
    drive(1'b1, 32'h500);
    step();
    drive(1'b0, 32'h0);
    chk("t5_fill1", fill, 1);
    chk("t5_head", rec.pc, 32'h500);
    ready = 1'b1;
    step();
    chk("t5_empty", valid, 0);
    ready = 1'b0;
    do_clear();
    for (int i = 0; i < 28; i++) begin
      drive(1'b1, 32'h600 + 32'(4 * i));
      step();
    end
    drive(1'b0, 32'h0);
    chk("t6_dc16", dc, 20);
    chk("t6_dc4_sat", dc4, 15);
    chk("t6_ovf4", ovf4, 1);
    ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t6_drain4", rec4.pc, 32'h600 + 32'(4 * i));
      step();
    end
    chk("t6_mk16", rec, marker_rec(32'h14));
    chk("t6_mk4", rec4, marker_rec(32'hF));
    step();
    chk("t6_empty4", valid4, 0);
    ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h700 + 32'(4 * i));
      step();
    end
    drive(1'b0, 32'h0);
    ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("t7_mid_fill", fill, 6);
    chk("t7_mid_pc", rec.pc, 32'h70c);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_valid", valid, 0);
    chk("t7_rec", rec, 0);
    chk("t7_fill", fill, 0);
    chk("t7_ovf", ovf, 0);
    chk("t7_dc", dc, 0);
    chk("t7_dc4", dc4, 0);
    #2;
    rst_n = 1'b1;
    step();
    chk("t7_post_valid", valid, 0);
    chk("t7_post_fill", fill, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
